// File: rtl/mmcm_reconfig_seq.sv
// mmcm_reconfig_seq: DRP read-modify-write reconfiguration, MMCM reset and lock qualification.
// Optional macro DRP_READBACK_VERIFY_EN adds a verify read after every register write.
module mmcm_reconfig_seq #(
   parameter int N_REGS             = 8,
   parameter int MODE_W             = 2,
   parameter int RST_CYCLES         = 16,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT       = 100000,
   parameter int DRDY_TIMEOUT       = 64
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic [MODE_W-1:0] mode_sel,
   input  logic              mode_req,
   output logic [MODE_W+3:0] tbl_idx,
   input  logic [38:0]       tbl_entry,
   output logic              drp_den,
   output logic              drp_dwe,
   output logic [6:0]        drp_daddr,
   output logic [15:0]       drp_di,
   input  logic [15:0]       drp_do,
   input  logic              drp_drdy,
   output logic              mmcm_rst,
   input  logic              mmcm_locked,
   output logic              video_rst,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err
);
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam int DW = $clog2(DRDY_TIMEOUT + 1);
   localparam int LW = $clog2(LOCK_TIMEOUT + 1);
   localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

   typedef enum logic [3:0] {
      IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, RST_OFF, WAIT_LOCK, STABLE
`ifdef DRP_READBACK_VERIFY_EN
      , VRD, VRD_WAIT
`endif
   } state_t;

   state_t            state;
   logic [1:0]        lk_s;
   logic [MODE_W-1:0] mode;
   logic [3:0]        idx;
   logic              norecfg;
   logic [15:0]       rdata;
   logic [RW-1:0]     rst_cnt;
   logic [DW-1:0]     drdy_cnt;
   logic [LW-1:0]     lock_cnt;
   logic [SW-1:0]     stab_cnt;
   logic              lk, last, drdy_to;

   assign lk      = lk_s[1];
   assign last    = idx == 4'(N_REGS - 1);
   assign drdy_to = drdy_cnt == DW'(DRDY_TIMEOUT - 1);
   assign tbl_idx = {mode, idx};

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state     <= WAIT_LOCK;
         lk_s      <= '0;
         mode      <= '0;
         idx       <= '0;
         norecfg   <= 1'b0;
         rdata     <= '0;
         rst_cnt   <= '0;
         drdy_cnt  <= '0;
         lock_cnt  <= '0;
         stab_cnt  <= '0;
         drp_den   <= 1'b0;
         drp_dwe   <= 1'b0;
         drp_daddr <= '0;
         drp_di    <= '0;
         mmcm_rst  <= 1'b0;
         video_rst <= 1'b1;
         busy      <= 1'b1;
         done      <= 1'b0;
         err       <= '0;
      end else begin
         lk_s    <= {lk_s[0], mmcm_locked};
         done    <= 1'b0;
         drp_den <= 1'b0;
         drp_dwe <= 1'b0;
         case (state)
            IDLE:
               if (mode_req || !lk) begin
                  mode      <= mode_req ? mode_sel : mode;
                  err       <= mode_req ? 2'b00 : err;
                  idx       <= mode_req ? 4'd0 : idx;
                  norecfg   <= !mode_req;
                  video_rst <= 1'b1;
                  busy      <= 1'b1;
                  mmcm_rst  <= 1'b1;
                  rst_cnt   <= '0;
                  state     <= RST_ON;
               end
            // mmcm_rst stays high through the table pass and is released in RST_OFF
            RST_ON:
               if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                  mmcm_rst <= !norecfg;
                  state    <= norecfg ? RST_OFF : RD;
               end else
                  rst_cnt <= rst_cnt + RW'(1);
            RD: begin
               drp_den   <= 1'b1;
               drp_daddr <= tbl_entry[38:32];
               drdy_cnt  <= '0;
               state     <= RD_WAIT;
            end
            RD_WAIT:
               if (drp_drdy) begin
                  rdata <= drp_do;
                  state <= WR;
               end else if (drdy_to) begin
                  err[0]   <= 1'b1;
                  mmcm_rst <= 1'b0;
                  state    <= RST_OFF;
               end else
                  drdy_cnt <= drdy_cnt + DW'(1);
            WR: begin
               drp_den  <= 1'b1;
               drp_dwe  <= 1'b1;
               drp_di   <= (rdata & tbl_entry[31:16]) | (tbl_entry[15:0] & ~tbl_entry[31:16]);
               drdy_cnt <= '0;
               state    <= WR_WAIT;
            end
            WR_WAIT:
               if (drp_drdy) begin
`ifdef DRP_READBACK_VERIFY_EN
                  state <= VRD;
`else
                  mmcm_rst <= !last;
                  idx      <= last ? idx : idx + 4'd1;
                  state    <= last ? RST_OFF : RD;
`endif
               end else if (drdy_to) begin
                  err[0]   <= 1'b1;
                  mmcm_rst <= 1'b0;
                  state    <= RST_OFF;
               end else
                  drdy_cnt <= drdy_cnt + DW'(1);
`ifdef DRP_READBACK_VERIFY_EN
            VRD: begin
               drp_den  <= 1'b1;
               drdy_cnt <= '0;
               state    <= VRD_WAIT;
            end
            VRD_WAIT:
               if (drp_drdy && drp_do != drp_di) begin
                  err[0]   <= 1'b1;
                  mmcm_rst <= 1'b0;
                  state    <= RST_OFF;
               end else if (drp_drdy) begin
                  mmcm_rst <= !last;
                  idx      <= last ? idx : idx + 4'd1;
                  state    <= last ? RST_OFF : RD;
               end else if (drdy_to) begin
                  err[0]   <= 1'b1;
                  mmcm_rst <= 1'b0;
                  state    <= RST_OFF;
               end else
                  drdy_cnt <= drdy_cnt + DW'(1);
`endif
            RST_OFF: begin
               lock_cnt <= '0;
               state    <= WAIT_LOCK;
            end
            WAIT_LOCK:
               if (lk) begin
                  stab_cnt <= '0;
                  state    <= STABLE;
               end else if (lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
                  err[1]   <= 1'b1;
                  norecfg  <= 1'b1;
                  mmcm_rst <= 1'b1;
                  rst_cnt  <= '0;
                  state    <= RST_ON;
               end else
                  lock_cnt <= lock_cnt + LW'(1);
            STABLE:
               if (!lk) begin
                  lock_cnt <= '0;
                  state    <= WAIT_LOCK;
               end else if (stab_cnt == SW'(LOCK_STABLE_CYCLES - 1)) begin
                  done      <= 1'b1;
                  video_rst <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else
                  stab_cnt <= stab_cnt + SW'(1);
            default: state <= WAIT_LOCK;
         endcase
      end
   end
endmodule

// File: doc/mmcm_reconfig_seq.md
Name: mmcm_reconfig_seq

Overview:
- Sequencer between the board clock domain and the pixel-clock MMCM.
- Switches video timing modes at run time by stepping a per-mode register table over the MMCM DRP port, using read-modify-write for each register.
- Controls MMCM reset, then qualifies lock over a stability window. Holds the downstream pixel-domain reset (video_rst) until the new clock is trustworthy.
- Also recovers from spontaneous loss of lock.

Parameters:
- N_REGS, 8: DRP registers written per mode (1..16).
- MODE_W, 2: mode-select width (2**MODE_W table modes).
- RST_CYCLES, 16: cycles mmcm_rst is held high per reset pulse (>=1).
- LOCK_STABLE_CYCLES, 1024: consecutive locked-high cycles required before release.
- LOCK_TIMEOUT, 100000: cycles allowed for lock after rst release.
- DRDY_TIMEOUT, 64: cycles allowed for drp_drdy after any DRP access.

Ports:
- clk_in, input, 1: board clock, also DRP DCLK.
- reset, input, 1: synchronous, active-high.
- mode_sel, input, MODE_W: requested mode, sampled only when mode_req=1 and busy=0.
- mode_req, input, 1: single-cycle request; ignored while busy=1.
- tbl_idx, output, MODE_W+4: {latched mode, entry index} into external table.
- tbl_entry, input, 39: {daddr[38:32], mask[31:16], data[15:0]}; combinational, valid same cycle.
- drp_den, output, 1: DRP enable (one-cycle pulse).
- drp_dwe, output, 1: DRP write enable (only with drp_den).
- drp_daddr, output, 7: DRP address.
- drp_di, output, 16: DRP write data.
- drp_do, input, 16: DRP read data, valid with drp_drdy.
- drp_drdy, input, 1: DRP access complete.
- mmcm_rst, output, 1: MMCM RST.
- mmcm_locked, input, 1: MMCM LOCKED; treated as async, 2-flop synchronised internally.
- video_rst, output, 1: downstream pixel-domain reset, active-high.
- busy, output, 1: reconfiguration or lock qualification in progress.
- done, output, 1: one-cycle pulse on successful completion.
- err, output, 2: sticky. Bit0 = DRDY timeout; bit1 = lock timeout. Cleared on reset or accepted mode_req.

Behaviour:
- Reset values:
  - mmcm_rst=0, video_rst=1, busy=1, done=0, err=0.
  - drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, tbl_idx=0.
  - State = WAIT_LOCK. The MMCM boots with its default configuration, so power-up does lock qualification only.
- States: IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, RST_OFF, WAIT_LOCK, STABLE.
- IDLE (busy=0, video_rst=0):
  - mode_req=1 latches mode_sel, clears err, sets idx=0, asserts video_rst the next cycle, and goes to RST_ON.
  - Synchronised lock low: video_rst=1 and go to RST_ON with no table pass (relock path, flag norecfg=1).
- RST_ON: mmcm_rst=1 for RST_CYCLES cycles. Then go to RD, or to RST_OFF if norecfg.
- RD: drp_den=1 (dwe=0) and daddr=tbl_entry.daddr for one cycle, then RD_WAIT.
- RD_WAIT:
  - On drp_drdy, capture drp_do and go to WR.
  - DRDY_TIMEOUT cycles without drdy: err[0]=1, go to RST_OFF (abort table pass, continue to lock attempt).
- WR:
  - One cycle with drp_den=1, drp_dwe=1.
  - drp_di = (rdata & mask) | (data & ~mask): mask bits set = keep.
- WR_WAIT:
  - drdy with idx<N_REGS-1 → idx++ and go to RD.
  - drdy with idx=N_REGS-1 → RST_OFF.
  - Timeout handled as in RD_WAIT.
- DRP rule: never more than one outstanding access. den is never reasserted before drdy or timeout. A drdy arriving in any state other than RD_WAIT/WR_WAIT is ignored.
- RST_OFF: mmcm_rst=0 for one cycle, reset lock counter, go to WAIT_LOCK.
- WAIT_LOCK:
  - Synchronised lock high → STABLE with stable counter=0.
  - Counter reaches LOCK_TIMEOUT → err[1]=1, norecfg=1, go to RST_ON. Retry is unlimited; the MMCM registers keep the new config.
- STABLE:
  - Counter increments while lock is high. Any low cycle returns to WAIT_LOCK with the timeout counter cleared.
  - Counter reaches LOCK_STABLE_CYCLES-1 → done=1 for one cycle, video_rst=0 and busy=0 in the same cycle, go to IDLE.
- Latency: successful mode switch ≥ RST_CYCLES + N_REGS*(4 + 2·drdy latency) + 1 + lock time + LOCK_STABLE_CYCLES cycles.
- Simultaneous events:
  - mode_req in the same cycle as lock loss in IDLE: mode_req wins (full reconfiguration).
  - reset in any state immediately forces reset values and aborts any DRP access. The MMCM is not re-reset; WAIT_LOCK re-qualifies it.
- Counters must be sized by $clog2 of their parameter and must not wrap.

Optional Feature:
- Macro DRP_READBACK_VERIFY_EN.
- Defined: after each WR_WAIT drdy, an extra read of the same address (states VRD/VRD_WAIT) compares drp_do against the written word.
  - Mismatch sets err[0] and aborts to RST_OFF.
  - Latency grows by one DRP read per register.
- Undefined: no readback; the states do not exist.

Test Plan:
- Power-up: reset 4 cycles, DRP model with locked rising 50 cycles after reset → video_rst falls and done pulses exactly LOCK_STABLE_CYCLES+2 (sync) cycles after lock rises. err=0, no drp_den seen.
- Mode switch: N_REGS=2, mode_req with mode_sel=1, table entries {0x08, mask 0x1000, data 0x0041} and drdy at 3-cycle latency, read value 0xFFFF → written di=0x1041. mmcm_rst high 16 cycles, then done after lock qualification.
- DRDY timeout: model never returns drdy on read → err=2'b01 after 64 cycles, mmcm_rst released, lock still qualified, done pulses.
- Lock timeout and retry: locked stays low (LOCK_TIMEOUT=200) → err[1]=1 and mmcm_rst pulses again for 16 cycles. Lock then asserted → done, err stays 2'b10 until next mode_req.
- Glitch and relock:
  - Lock drops for 1 cycle during STABLE → stable count restarts, with no done until a full window.
  - Lock loss in IDLE → video_rst=1 and mmcm_rst pulse with no DRP traffic.
- Request collisions:
  - mode_req while busy → ignored: tbl_idx mode unchanged, no extra DRP accesses.
  - reset asserted mid-RD_WAIT → drp_den=0, busy=1 next cycle.
